// File: rtl/reg_slice_fifo.sv
// ---------------------------------------------------------------------------
// reg_slice_fifo
//
// Small synchronous FIFO used as a registered pipeline slice between two
// valid/ready stages. Both handshake outputs come straight from flops, so
// this slice breaks every combinational path between the upstream and
// downstream stages. Data written on one rising edge becomes visible at the
// output after that edge; there is no same-cycle bypass.
//
// Parameters
//   DATA_WIDTH    payload width in bits (>= 1)
//   DEPTH         number of entries (power of two, >= 2)
//   AFULL_THRESH  occupancy at or above which almost_full_o is high (1..DEPTH)
//
// Ports
//   aclk                single clock, rising edge
//   areset              synchronous active-high reset, highest priority
//   flush_i             synchronous discard of all stored entries
//   prev_stage_data_i   upstream payload
//   prev_stage_valid_i  upstream valid
//   prev_stage_ready_o  upstream ready (registered "not full")
//   next_stage_data_o   downstream payload (zero while empty)
//   next_stage_valid_o  downstream valid (registered "not empty")
//   next_stage_ready_i  downstream ready
//   count_o             current occupancy, 0..DEPTH
//   almost_full_o       registered flag, high when count_o >= AFULL_THRESH
// ---------------------------------------------------------------------------
module reg_slice_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       flush_i,
    input  logic [DATA_WIDTH-1:0]      prev_stage_data_i,
    input  logic                       prev_stage_valid_i,
    output logic                       prev_stage_ready_o,
    output logic [DATA_WIDTH-1:0]      next_stage_data_o,
    output logic                       next_stage_valid_o,
    input  logic                       next_stage_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       almost_full_o
);

    // Address width indexes the storage; pointer width adds one wrap bit so
    // that full and empty can be told apart when the low bits match.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AfullCnt = PW'(AFULL_THRESH);

    // Parameter sanity checks, evaluated at elaboration only.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
            $error("reg_slice_fifo: DEPTH must be a power of two and at least 2");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : gThreshCheck
            $error("reg_slice_fifo: AFULL_THRESH must lie in 1..DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wrPtr_q,  wrPtr_d;
    logic [PW-1:0] rdPtr_q,  rdPtr_d;
    logic [PW-1:0] count_q,  count_d;
    logic          empty_q,  empty_d;
    logic          full_q,   full_d;
    logic          almostFull_q, almostFull_d;

    logic push;
    logic pop;

    // Handshakes are qualified only by registered flags, so neither ready
    // nor valid depends combinationally on the opposite side. A flush
    // cancels any transfer offered in the same cycle.
    assign push = prev_stage_valid_i & ~full_q  & ~flush_i;
    assign pop  = next_stage_ready_i & ~empty_q & ~flush_i;

    // Next-state pointers, occupancy and flags. Empty/full/almost-full are
    // derived from the next-state values here so that the registered
    // copies always agree with the registered pointers and count.
    always_comb begin
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        empty_d      = empty_q;
        full_d       = full_q;
        almostFull_d = almostFull_q;

        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (push && !pop) begin
                count_d = count_q + {{(PW-1){1'b0}}, 1'b1};
            end else if (pop && !push) begin
                count_d = count_q - {{(PW-1){1'b0}}, 1'b1};
            end
        end

        empty_d      = (wrPtr_d == rdPtr_d);
        full_d       = (wrPtr_d[PW-1] != rdPtr_d[PW-1]) &&
                       (wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]);
        almostFull_d = (count_d >= AfullCnt);
    end

    // Control state register. Reset wins over flush and any handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            almostFull_q <= 1'b0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            almostFull_q <= almostFull_d;
        end
    end

    // Payload storage. Entries are cleared on reset so the output can never
    // show stale or unknown data; a flush leaves the contents in place
    // because the zeroed pointers make them unreachable anyway.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wrPtr_q[AW-1:0]] <= prev_stage_data_i;
        end
    end

    // Outputs come from registered state only. Data is forced to zero while
    // empty so downstream never sees an old entry alongside valid low.
    assign prev_stage_ready_o = ~full_q;
    assign next_stage_valid_o = ~empty_q;
    assign next_stage_data_o  = empty_q ? '0 : mem_q[rdPtr_q[AW-1:0]];
    assign count_o            = count_q;
    assign almost_full_o      = almostFull_q;

endmodule

// File: tb/tb_reg_slice_fifo.sv
// ---------------------------------------------------------------------------
// tb_reg_slice_fifo
//
// Self-checking bench for reg_slice_fifo with DATA_WIDTH=8, DEPTH=4,
// AFULL_THRESH=3. A table of hand-derived vectors covers reset, fill and
// drain; short hand-written sequences cover streaming with wrap, flush and
// mid-stream reset; a randomized phase is checked against a queue-based
// reference model of the FIFO.
// ---------------------------------------------------------------------------
module tb_reg_slice_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;

    logic          aclk;
    logic          areset;
    logic          flushI;
    logic [DW-1:0] dataI;
    logic          validI;
    logic          readyO;
    logic [DW-1:0] dataO;
    logic          validO;
    logic          readyI;
    logic [2:0]    countO;
    logic          afullO;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the FIFO contents as a plain queue.
    logic [DW-1:0] model[$];

    typedef struct {
        logic          rst;
        logic          flush;
        logic          vin;
        logic [DW-1:0] din;
        logic          rdy;
        logic          expReady;
        logic          expValid;
        logic [DW-1:0] expData;
        logic [2:0]    expCount;
        logic          expAfull;
    } vec_t;

    vec_t tbl[13];

    reg_slice_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_THRESH(AFT)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .flush_i           (flushI),
        .prev_stage_data_i (dataI),
        .prev_stage_valid_i(validI),
        .prev_stage_ready_o(readyO),
        .next_stage_data_o (dataO),
        .next_stage_valid_o(validO),
        .next_stage_ready_i(readyI),
        .count_o           (countO),
        .almost_full_o     (afullO)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Drive one cycle of inputs, let the clock edge happen, advance the
    // model with the same inputs, then settle 1ns past the edge for checks.
    task automatic applyStimulus(input logic rst, input logic flush,
                                 input logic vin, input logic [DW-1:0] din,
                                 input logic rdy);
        bit doPush;
        bit doPop;
        logic [DW-1:0] junk;
        areset = rst;
        flushI = flush;
        validI = vin;
        dataI  = din;
        readyI = rdy;
        @(posedge aclk);
        if (rst || flush) begin
            model.delete();
        end else begin
            doPush = vin && (model.size() < DEPTH);
            doPop  = rdy && (model.size() > 0);
            if (doPop)  junk = model.pop_front();
            if (doPush) model.push_back(din);
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eReady,
                               input logic eValid, input logic [DW-1:0] eData,
                               input logic [2:0] eCount, input logic eAfull);
        vectors++;
        if (readyO !== eReady || validO !== eValid || dataO !== eData ||
            countO !== eCount || afullO !== eAfull) begin
            miscompares++;
            $display("[TB] FAIL %s: got rdy=%0b vld=%0b data=%02h cnt=%0d af=%0b, expected rdy=%0b vld=%0b data=%02h cnt=%0d af=%0b",
                     name, readyO, validO, dataO, countO, afullO,
                     eReady, eValid, eData, eCount, eAfull);
        end
    endtask

    task automatic checkModel(input string name);
        int n;
        n = model.size();
        checkOutput(name, n < DEPTH, n > 0, (n > 0) ? model[0] : 8'h00,
                    3'(n), n >= AFT);
    endtask

    initial begin
        logic [DW-1:0] nextVal;

        areset = 1'b1;
        flushI = 1'b0;
        validI = 1'b0;
        dataI  = '0;
        readyI = 1'b0;

        //          rst  fl   vin  din    rdy  | rdyO vldO data   cnt  af
        tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,3'd0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,3'd0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b1,8'h11,1'b0, 1'b1,1'b1,8'h11,3'd1,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b1,8'h22,1'b0, 1'b1,1'b1,8'h11,3'd2,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b1,8'h33,1'b0, 1'b1,1'b1,8'h11,3'd3,1'b1};
        tbl[5]  = '{1'b0,1'b0,1'b1,8'h44,1'b0, 1'b0,1'b1,8'h11,3'd4,1'b1};
        tbl[6]  = '{1'b0,1'b0,1'b1,8'h55,1'b0, 1'b0,1'b1,8'h11,3'd4,1'b1};
        tbl[7]  = '{1'b0,1'b0,1'b1,8'h55,1'b0, 1'b0,1'b1,8'h11,3'd4,1'b1};
        tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h22,3'd3,1'b1};
        tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h33,3'd2,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h44,3'd1,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h00,3'd0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h00,3'd0,1'b0};

        @(negedge aclk);

        // Reset, idle, fill to full with a held extra value, drain.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].flush, tbl[i].vin, tbl[i].din,
                          tbl[i].rdy);
            checkOutput($sformatf("table[%0d]", i), tbl[i].expReady,
                        tbl[i].expValid, tbl[i].expData, tbl[i].expCount,
                        tbl[i].expAfull);
        end

        // Streaming at constant occupancy 2; pointers wrap several times.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        checkOutput("stream_pre", 1'b1, 1'b1, 8'hA0, 3'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'hA2 + i), 1'b1);
            checkOutput($sformatf("stream[%0d]", i), 1'b1, 1'b1,
                        8'(8'hA1 + i), 3'd2, 1'b0);
        end

        // Flush at occupancy 3 with push and pop offered together.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB0, 1'b0);
        checkOutput("flush_pre", 1'b1, 1'b1, 8'hAA, 3'd3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hB1, 1'b1);
        checkOutput("flush_now", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("flush_after", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);

        // Reset mid-stream at occupancy 2, then refill and drain in order.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);
        checkOutput("rst_pre", 1'b1, 1'b1, 8'hC0, 3'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hC2, 1'b1);
        checkOutput("rst_now", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hD0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hD1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hD2, 1'b0);
        checkOutput("rst_refill", 1'b1, 1'b1, 8'hD0, 3'd3, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rst_drain0", 1'b1, 1'b1, 8'hD1, 3'd2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rst_drain1", 1'b1, 1'b1, 8'hD2, 3'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rst_drain2", 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);

        // Randomized traffic against the queue model.
        nextVal = 8'h01;
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic f;
            logic v;
            logic k;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 31) == 0);
            v = ($urandom_range(0, 3) != 0);
            k = ($urandom_range(0, 2) != 0);
            applyStimulus(r, f, v, nextVal, k);
            checkModel($sformatf("random[%0d]", i));
            nextVal = 8'($urandom_range(0, 255));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
